// File: rtl/mbscore_mem_responder.sv
// mbscore_mem_responder: single-port word memory that serves an instruction
// fetch port and a data load/store port. One transaction is in flight at a
// time. The response appears a fixed LATENCY cycles after the handshake.
module mbscore_mem_responder #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 10,
    parameter int LATENCY    = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  if_req,
    input  logic [31:0]           if_addr,
    output logic                  if_ready,
    output logic                  if_rvalid,
    output logic [DATA_WIDTH-1:0] if_rdata,
    input  logic                  d_req,
    input  logic                  d_we,
    input  logic [3:0]            d_be,
    input  logic [31:0]           d_addr,
    input  logic [DATA_WIDTH-1:0] d_wdata,
    output logic                  d_ready,
    output logic                  d_rvalid,
    output logic [DATA_WIDTH-1:0] d_rdata,
    output logic                  d_err
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_BUSY  = 2'd1;
    localparam logic [1:0] ST_RESP  = 2'd2;
    localparam logic [3:0] LAT_LAST = 4'(LATENCY - 1);
    localparam int         DEPTH    = 1 << ADDR_WIDTH;

    // A data access is misaligned when either low byte-address bit is set.
    function automatic logic misaligned(input logic [1:0] lo);
        return (lo != 2'b00);
    endfunction

    // Replace the bytes of old_word selected by be with the bytes of new_word.
    function automatic logic [DATA_WIDTH-1:0] merge_bytes(
        input logic [DATA_WIDTH-1:0] old_word,
        input logic [DATA_WIDTH-1:0] new_word,
        input logic [3:0]            be
    );
        logic [DATA_WIDTH-1:0] res;
        res = old_word;
        for (int i = 0; i < 4; i++) begin
            if (be[i]) begin
                res[8*i +: 8] = new_word[8*i +: 8];
            end
        end
        return res;
    endfunction

    logic [1:0]            state_r;
    logic [1:0]            state_nxt_s;
    logic [3:0]            lat_cnt_r;
    logic [1:0]            starve_r;

    logic                  sel_data_r;
    logic                  we_r;
    logic                  err_r;
    logic [3:0]            be_r;
    logic [ADDR_WIDTH-1:0] idx_r;
    logic [DATA_WIDTH-1:0] wdata_r;

    logic [DATA_WIDTH-1:0] mem_r [DEPTH];

    logic                  if_grant_s;
    logic                  d_grant_s;
    logic                  hs_s;
    logic                  enter_resp_s;

    logic                  rd_sel_data_s;
    logic                  rd_we_s;
    logic                  rd_err_s;
    logic [ADDR_WIDTH-1:0] rd_idx_s;
    logic [DATA_WIDTH-1:0] rd_word_s;

    logic                  if_rvalid_r;
    logic [DATA_WIDTH-1:0] if_rdata_r;
    logic                  d_rvalid_r;
    logic [DATA_WIDTH-1:0] d_rdata_r;
    logic                  d_err_r;

    // Upper address bits alias by design; fetch low bits are don't-care.
    logic unused_addr_bits_s;
    assign unused_addr_bits_s = ^{if_addr[31:ADDR_WIDTH+2], if_addr[1:0],
                                  d_addr[31:ADDR_WIDTH+2]};

    // Arbitration: data wins unless fetch has lost twice in a row; no grant outside IDLE or in reset.
    always_comb begin
        if_grant_s = 1'b0;
        d_grant_s  = 1'b0;
        if (!rst && (state_r == ST_IDLE)) begin
            if (if_req && (!d_req || (starve_r == 2'd2))) begin
                if_grant_s = 1'b1;
            end else if (d_req) begin
                d_grant_s = 1'b1;
            end else begin
                if_grant_s = 1'b0;
                d_grant_s  = 1'b0;
            end
        end else begin
            if_grant_s = 1'b0;
            d_grant_s  = 1'b0;
        end
    end

    assign hs_s     = if_grant_s | d_grant_s;
    assign if_ready = if_grant_s;
    assign d_ready  = d_grant_s;

    // Next-state logic; enter_resp_s marks the edge that loads the response registers.
    always_comb begin
        state_nxt_s  = state_r;
        enter_resp_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (hs_s) begin
                    if (LATENCY == 1) begin
                        state_nxt_s  = ST_RESP;
                        enter_resp_s = 1'b1;
                    end else begin
                        state_nxt_s = ST_BUSY;
                    end
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_BUSY: begin
                if (lat_cnt_r == LAT_LAST) begin
                    state_nxt_s  = ST_RESP;
                    enter_resp_s = 1'b1;
                end else begin
                    state_nxt_s = ST_BUSY;
                end
            end
            ST_RESP: begin
                state_nxt_s = ST_IDLE;
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Read source: live request fields on the handshake edge (LATENCY=1), captured fields otherwise.
    always_comb begin
        if (state_r == ST_IDLE) begin
            rd_sel_data_s = d_grant_s;
            rd_we_s       = d_we;
            rd_err_s      = d_grant_s & misaligned(d_addr[1:0]);
            rd_idx_s      = d_grant_s ? d_addr[ADDR_WIDTH+1:2] : if_addr[ADDR_WIDTH+1:2];
        end else begin
            rd_sel_data_s = sel_data_r;
            rd_we_s       = we_r;
            rd_err_s      = err_r;
            rd_idx_s      = idx_r;
        end
        rd_word_s = mem_r[rd_idx_s];
    end

    // FSM state, latency counter and fetch starvation counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= ST_IDLE;
            lat_cnt_r <= 4'd0;
            starve_r  <= 2'd0;
        end else begin
            state_r <= state_nxt_s;
            if (hs_s) begin
                lat_cnt_r <= 4'd1;
            end else if (state_r == ST_BUSY) begin
                lat_cnt_r <= lat_cnt_r + 4'd1;
            end else begin
                lat_cnt_r <= 4'd0;
            end
            if (if_grant_s) begin
                starve_r <= 2'd0;
            end else if (d_grant_s && if_req && (starve_r != 2'd2)) begin
                starve_r <= starve_r + 2'd1;
            end else begin
                starve_r <= starve_r;
            end
        end
    end

    // Capture the granted request so later input changes cannot disturb it.
    always_ff @(posedge clk) begin
        if (rst) begin
            sel_data_r <= 1'b0;
            we_r       <= 1'b0;
            err_r      <= 1'b0;
            be_r       <= 4'd0;
            idx_r      <= {ADDR_WIDTH{1'b0}};
            wdata_r    <= {DATA_WIDTH{1'b0}};
        end else if (hs_s) begin
            sel_data_r <= d_grant_s;
            we_r       <= d_grant_s & d_we;
            err_r      <= d_grant_s & misaligned(d_addr[1:0]);
            be_r       <= d_be;
            idx_r      <= d_grant_s ? d_addr[ADDR_WIDTH+1:2] : if_addr[ADDR_WIDTH+1:2];
            wdata_r    <= d_wdata;
        end else begin
            sel_data_r <= sel_data_r;
            we_r       <= we_r;
            err_r      <= err_r;
            be_r       <= be_r;
            idx_r      <= idx_r;
            wdata_r    <= wdata_r;
        end
    end

    // Response registers: loaded for exactly the RESP cycle, zero at all other times.
    always_ff @(posedge clk) begin
        if (rst) begin
            if_rvalid_r <= 1'b0;
            if_rdata_r  <= {DATA_WIDTH{1'b0}};
            d_rvalid_r  <= 1'b0;
            d_rdata_r   <= {DATA_WIDTH{1'b0}};
            d_err_r     <= 1'b0;
        end else if (enter_resp_s) begin
            if_rvalid_r <= ~rd_sel_data_s;
            if_rdata_r  <= rd_sel_data_s ? {DATA_WIDTH{1'b0}} : rd_word_s;
            d_rvalid_r  <= rd_sel_data_s;
            d_rdata_r   <= (rd_sel_data_s && !rd_we_s && !rd_err_s) ? rd_word_s
                                                                    : {DATA_WIDTH{1'b0}};
            d_err_r     <= rd_sel_data_s & rd_err_s;
        end else begin
            if_rvalid_r <= 1'b0;
            if_rdata_r  <= {DATA_WIDTH{1'b0}};
            d_rvalid_r  <= 1'b0;
            d_rdata_r   <= {DATA_WIDTH{1'b0}};
            d_err_r     <= 1'b0;
        end
    end

    // Store commit at the edge ending RESP; a reset at that edge drops the write.
    always_ff @(posedge clk) begin
        if (!rst && (state_r == ST_RESP) && sel_data_r && we_r && !err_r) begin
            mem_r[idx_r] <= merge_bytes(mem_r[idx_r], wdata_r, be_r);
        end
    end

    assign if_rvalid = if_rvalid_r;
    assign if_rdata  = if_rdata_r;
    assign d_rvalid  = d_rvalid_r;
    assign d_rdata   = d_rdata_r;
    assign d_err     = d_err_r;

endmodule

// File: doc/mbscore_mem_responder.md
MBSCORE_MEM_RESPONDER -- requirements
Module: mbscore_mem_responder

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, width of a memory word and all data ports.
REQ-002 SHALL have parameter ADDR_WIDTH, default 10, log2 of word depth (1024 words).
REQ-003 SHALL have parameter LATENCY, default 2, cycles from accepted request to response; legal range 1..15.
REQ-004 SHALL have ports: clk  in  1  single clock, all logic on rising edge.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 if_req  in  1  instruction-fetch request, held until accepted.
REQ-007 if_addr  in  32  fetch byte address.
REQ-008 if_ready  out  1  fetch accepted this cycle.
REQ-009 if_rvalid  out  1  fetch data valid, one-cycle pulse.
REQ-010 if_rdata  out  DATA_WIDTH  fetched instruction word.
REQ-011 d_req  in  1  data request, held until accepted; d_we  in  1  1=store, 0=load.
REQ-012 d_be  in  4  store byte enables, bit i -> byte i (bits 8i+7:8i).
REQ-013 d_addr  in  32  data byte address; d_wdata  in  DATA_WIDTH  store data.
REQ-014 d_ready  out  1  data request accepted this cycle.
REQ-015 d_rvalid  out  1  data response pulse (load data or store completion).
REQ-016 d_rdata  out  DATA_WIDTH  load data; d_err  out  1  misaligned data access, valid with d_rvalid.

Function
REQ-017 Handshake: a port transfer occurs in a cycle where req=1 and ready=1; ready SHALL be 0 unless the FSM is IDLE.
REQ-018 FSM states IDLE, BUSY, RESP; IDLE->BUSY on any handshake (LATENCY>1), IDLE->RESP directly when LATENCY=1, BUSY->RESP when latency counter reaches LATENCY-1, RESP->IDLE unconditionally.
REQ-019 One transaction in flight; no request accepted in BUSY or RESP, including the RESP cycle.
REQ-020 Arbitration in IDLE: data wins when both requests present, except fetch wins when it has lost 2 consecutive arbitrations (starvation counter, cleared on any fetch grant).
REQ-021 At most one of if_ready/d_ready SHALL be 1 in any cycle; ready SHALL be combinational from req and state.
REQ-022 Request fields (port, we, be, word index, wdata) SHALL be captured at the handshake edge; later input changes have no effect.
REQ-023 Word index = addr[ADDR_WIDTH+1:2]; upper address bits ignored (aliasing wrap-around).
REQ-024 rvalid for the granted port SHALL be 1 exactly LATENCY cycles after the handshake cycle, for exactly one cycle.
REQ-025 Load/fetch: rdata in the rvalid cycle equals memory word at captured index, as of all stores completed before this request's handshake.
REQ-026 Store: bytes with be=1 written at the rising edge ending the d_rvalid cycle; be=0 bytes unchanged; d_rdata=0 for stores.
REQ-027 d_err=1 with d_rvalid when captured d_addr[1:0]!=0; such a store SHALL NOT modify memory, such a load returns d_rdata=0.
REQ-028 Fetch address bits [1:0] ignored; fetch never errors.
REQ-029 rdata outputs SHALL hold 0 when the corresponding rvalid is 0.
REQ-030 Store with d_be=0 completes normally (rvalid, d_err per REQ-027) and writes nothing.

Reset
REQ-031 rst=1 at an edge SHALL force: state IDLE, latency and starvation counters 0, all outputs 0 (ready, rvalid, rdata, d_err).
REQ-032 Reset mid-transaction SHALL drop it: no rvalid, no memory write, even if asserted in the RESP cycle.
REQ-033 Memory array contents SHALL NOT be reset; ready may assert the first cycle after rst deasserts.

Verification
REQ-034 Store 0xDEADBEEF be=1111 to 0x40, then load 0x40 -> d_rvalid 2 cycles after each handshake, load d_rdata=0xDEADBEEF, d_err=0.
REQ-035 Store 0x000000AA be=0001 to 0x40 over 0xDEADBEEF, load 0x40 -> 0xDEADBEAA; load 0x42 -> d_err=1, d_rdata=0, memory unchanged.
REQ-036 if_req and d_req held high continuously -> grant order D,D,I,D,D,I...; never both ready in one cycle; each rvalid 2 cycles after its grant.
REQ-037 Store to 0x40 then load 0x1040 (ADDR_WIDTH=10) -> aliased data returned.
REQ-038 Assert rst for 1 cycle during BUSY of a store to 0x80 -> no d_rvalid, word at 0x80 unchanged, outputs 0, next request accepted the cycle after rst drops.
REQ-039 Rebuild with LATENCY=1 and LATENCY=5 -> rvalid 1 and 5 cycles after handshake respectively, back-to-back requests accepted every LATENCY+1 cycles.
